// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers: round-robin
// arbitration, optional per-requester lock, and go/bsy handshake sequencing.
module uart_tx_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                 rst_n,
  input  logic                 i_clk,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_lock,
  output logic [NUM_REQ-1:0]   o_req_ack,
  output logic [7:0]           o_uart_data,
  output logic                 o_uart_go,
  input  logic                 i_uart_bsy,
  output logic [IW-1:0]        o_grant_id,
  output logic                 o_active,
  output logic [1:0]           o_state
);

  // Handshakes: a requester holds valid/data until its single-cycle ack, and a
  // valid still high the cycle after ack is a new byte. Toward the transmitter,
  // go rises with the latched byte, bsy rising then falling ends the frame, and
  // go is then held low for at least one full cycle before the next frame.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t               r_state;
  logic [7:0]           r_uart_data;
  logic                 r_uart_go;
  logic [NUM_REQ-1:0]   r_req_ack;
  logic [IW-1:0]        r_grant_id;
  logic [IW-1:0]        r_rr_ptr;
  logic                 r_locked;
  logic                 r_active;

  state_t               w_state_nxt;
  logic [7:0]           w_data_nxt;
  logic                 w_go_nxt;
  logic [NUM_REQ-1:0]   w_ack_nxt;
  logic [IW-1:0]        w_grant_nxt;
  logic [IW-1:0]        w_rr_nxt;
  logic                 w_locked_nxt;
  logic                 w_active_nxt;

  logic                 w_any_valid;
  logic                 w_lock_hit;
  logic [IW-1:0]        w_rr_win;
  logic [IW-1:0]        w_win;
  logic [7:0]           w_win_data;

  // Index base+step wrapped at NUM_REQ; step never exceeds NUM_REQ.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IW'(sum);
  endfunction

  assign w_any_valid = |i_req_valid;
  assign w_lock_hit  = r_locked && i_req_valid[r_grant_id];
  assign w_win       = w_lock_hit ? r_grant_id : w_rr_win;

  // Scan from farthest to nearest so the nearest valid after rr_ptr wins.
  always_comb begin
    w_rr_win = r_rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_req_valid[rr_index(r_rr_ptr, k)]) w_rr_win = rr_index(r_rr_ptr, k);
    end
  end

  always_comb begin
    w_win_data = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IW'(k) == w_win) w_win_data = i_req_data[k*8 +: 8];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_uart_data;
    w_go_nxt     = r_uart_go;
    w_ack_nxt    = '0;
    w_grant_nxt  = r_grant_id;
    w_rr_nxt     = r_rr_ptr;
    w_locked_nxt = r_locked;
    w_active_nxt = r_active;
    case (r_state)
      S_IDLE: begin
        if (r_locked && !i_req_valid[r_grant_id]) w_locked_nxt = 1'b0;
        if (w_any_valid) begin
          w_data_nxt   = w_win_data;
          w_go_nxt     = 1'b1;
          w_grant_nxt  = w_win;
          w_rr_nxt     = w_win;
          w_active_nxt = 1'b1;
          w_state_nxt  = S_ISSUE;
          for (int k = 0; k < NUM_REQ; k++) w_ack_nxt[k] = (IW'(k) == w_win);
        end
      end
      S_ISSUE: begin
        if (i_uart_bsy) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (!i_uart_bsy) begin
          w_go_nxt     = 1'b0;
          w_active_nxt = 1'b0;
          w_locked_nxt = i_req_lock[r_grant_id];
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_uart_data <= 8'h00;
      r_uart_go   <= 1'b0;
      r_req_ack   <= '0;
      r_grant_id  <= '0;
      r_rr_ptr    <= IW'(NUM_REQ - 1);
      r_locked    <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_uart_data <= w_data_nxt;
      r_uart_go   <= w_go_nxt;
      r_req_ack   <= w_ack_nxt;
      r_grant_id  <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_locked    <= w_locked_nxt;
      r_active    <= w_active_nxt;
    end
  end

  assign o_req_ack   = r_req_ack;
  assign o_uart_data = r_uart_data;
  assign o_uart_go   = r_uart_go;
  assign o_grant_id  = r_grant_id;
  assign o_active    = r_active;
  assign o_state     = r_state;

  a_ack_onehot: assert property (@(posedge i_clk) disable iff (!rst_n)
    $onehot0(r_req_ack));
  a_ack_only_on_grant: assert property (@(posedge i_clk) disable iff (!rst_n)
    (r_req_ack != '0) |-> (r_state == S_ISSUE));
  a_grant_in_range: assert property (@(posedge i_clk) disable iff (!rst_n)
    int'(r_grant_id) < NUM_REQ);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: a 2-requester arbiter driving a bit-level UART model and a
// 3-requester arbiter driving a short bsy responder for round-robin wrap.
module tb_uart_tx_arbiter;
  localparam int BIT_TIME = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- 2-requester instance ----------------
  logic [1:0]  req_valid2, req_lock2, req_ack2;
  logic [15:0] req_data2;
  logic [7:0]  uart_data2;
  logic        uart_go2, uart_bsy2, active2;
  logic [0:0]  grant2;
  logic [1:0]  state2;

  uart_tx_arbiter #(.NUM_REQ(2)) u_dut2 (
    .rst_n(rst_n), .i_clk(clk),
    .i_req_valid(req_valid2), .i_req_data(req_data2), .i_req_lock(req_lock2),
    .o_req_ack(req_ack2), .o_uart_data(uart_data2), .o_uart_go(uart_go2),
    .i_uart_bsy(uart_bsy2), .o_grant_id(grant2), .o_active(active2), .o_state(state2)
  );

  // ---------------- 3-requester instance ----------------
  logic [2:0]  req_valid3, req_lock3, req_ack3;
  logic [23:0] req_data3;
  logic [7:0]  uart_data3;
  logic        uart_go3, uart_bsy3, active3;
  logic [1:0]  grant3;
  logic [1:0]  state3;

  uart_tx_arbiter #(.NUM_REQ(3)) u_dut3 (
    .rst_n(rst_n), .i_clk(clk),
    .i_req_valid(req_valid3), .i_req_data(req_data3), .i_req_lock(req_lock3),
    .o_req_ack(req_ack3), .o_uart_data(uart_data3), .o_uart_go(uart_go3),
    .i_uart_bsy(uart_bsy3), .o_grant_id(grant3), .o_active(active3), .o_state(state3)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- UART transmitter model (negedge) ----------------
  typedef enum logic [1:0] {T_IDLE, T_SHIFT, T_WAITLOW} tx_st_t;
  tx_st_t     tx_st;
  int         tx_tick, tx_bit;
  logic [9:0] rx_bits;
  logic [7:0] tx_byte;
  logic       stab_bad, frame_done, line2;

  always_comb begin
    line2 = 1'b1;
    if (tx_st == T_SHIFT) begin
      if (tx_bit == 0)      line2 = 1'b0;
      else if (tx_bit <= 8) line2 = uart_data2[tx_bit-1];
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st <= T_IDLE; uart_bsy2 <= 1'b0; tx_tick <= 0; tx_bit <= 0;
      rx_bits <= '0; tx_byte <= '0; stab_bad <= 1'b0; frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (tx_st)
        T_IDLE: if (uart_go2) begin
          uart_bsy2 <= 1'b1; tx_st <= T_SHIFT; tx_tick <= 0; tx_bit <= 0;
          tx_byte <= uart_data2; stab_bad <= 1'b0;
        end
        T_SHIFT: begin
          if (uart_data2 !== tx_byte) stab_bad <= 1'b1;
          if (tx_tick == 1) rx_bits[tx_bit] <= line2;
          if (tx_tick == BIT_TIME-1) begin
            tx_tick <= 0;
            if (tx_bit == 9) begin
              uart_bsy2 <= 1'b0; frame_done <= 1'b1; tx_st <= T_WAITLOW;
            end else begin
              tx_bit <= tx_bit + 1;
            end
          end else begin
            tx_tick <= tx_tick + 1;
          end
        end
        T_WAITLOW: if (!uart_go2) tx_st <= T_IDLE;
        default: tx_st <= T_IDLE;
      endcase
    end
  end

  // Decoded line byte against the expected queue.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      check("start_bit", rx_bits[0], 1'b0);
      check("stop_bit", rx_bits[9], 1'b1);
      check("data_stable", stab_bad, 1'b0);
      check("frame_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) check("line_byte", rx_bits[8:1], exp_q.pop_front());
    end
  end

  // go high length per frame and low gap between frames.
  int   go_hi, go_lo;
  logic go_prev, had_frame;
  always @(negedge clk) begin
    if (!rst_n) begin
      go_hi <= 0; go_lo <= 0; go_prev <= 1'b0; had_frame <= 1'b0;
    end else begin
      go_prev <= uart_go2;
      if (uart_go2) begin
        go_hi <= go_prev ? go_hi + 1 : 1;
        if (!go_prev && had_frame) check("go_low_gap", (go_lo >= 1), 1'b1);
      end else if (go_prev) begin
        go_lo <= 1;
        had_frame <= 1'b1;
        check("go_high_len", go_hi, 41);
      end else begin
        go_lo <= go_lo + 1;
      end
    end
  end

  // ---------------- bsy responder for the 3-requester instance ----------------
  logic bsy3_wait;
  int   bsy3_cnt;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_bsy3 <= 1'b0; bsy3_wait <= 1'b0; bsy3_cnt <= 0;
    end else if (bsy3_wait) begin
      if (!uart_go3) bsy3_wait <= 1'b0;
    end else if (uart_bsy3) begin
      if (bsy3_cnt == 3) begin
        uart_bsy3 <= 1'b0; bsy3_wait <= 1'b1;
      end else begin
        bsy3_cnt <= bsy3_cnt + 1;
      end
    end else if (uart_go3) begin
      uart_bsy3 <= 1'b1; bsy3_cnt <= 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    req_valid2 = '0; req_lock2 = '0; req_data2 = '0;
    req_valid3 = '0; req_lock3 = '0; req_data3 = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ack2(input string tag, output logic [1:0] ack);
    ack = '0;
    for (int i = 0; i < 200 && ack == '0; i++) begin
      @(negedge clk); #1;
      ack = req_ack2;
    end
    check({tag, "_seen"}, (ack != '0), 1'b1);
  endtask

  task automatic wait_ack3(input string tag, output logic [2:0] ack);
    ack = '0;
    for (int i = 0; i < 100 && ack == '0; i++) begin
      @(negedge clk); #1;
      ack = req_ack3;
    end
    check({tag, "_seen"}, (ack != '0), 1'b1);
  endtask

  task automatic wait_idle2(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); #1;
      done = !uart_go2 && (tx_st == T_IDLE) && (exp_q.size() == 0);
    end
    check({tag, "_idle"}, done, 1'b1);
  endtask

  task automatic wait_idle3(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); #1;
      done = !uart_go3 && !uart_bsy3 && !bsy3_wait;
    end
    check({tag, "_idle"}, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  logic [1:0] ack2;
  logic [2:0] ack3;
  logic [1:0] t2_ack[4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic       t2_gid[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [2:0] t6_ack[5]  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100};
  logic [1:0] t6_gid[5]  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
  logic [7:0] t6_data[5] = '{8'hC0, 8'hC1, 8'hC2, 8'hC0, 8'hC2};

  initial begin
    rst_n = 1'b0;
    req_valid2 = '0; req_lock2 = '0; req_data2 = '0;
    req_valid3 = '0; req_lock3 = '0; req_data3 = '0;
    #3;
    check("rst_state", state2, 2'd0);
    check("rst_go", uart_go2, 1'b0);
    check("rst_active", active2, 1'b0);
    check("rst_ack", req_ack2, 2'b00);
    check("rst_grant", grant2, 1'b0);
    check("rst_data", uart_data2, 8'h00);
    check("rst_go3", uart_go3, 1'b0);
    check("rst_grant3", grant3, 2'd0);
    do_reset();

    // Single requester, 0x55: ack and go one cycle after valid.
    req_data2[7:0] = 8'h55; req_valid2 = 2'b01; exp_q.push_back(8'h55);
    @(negedge clk); #1;
    check("t1_ack", req_ack2, 2'b01);
    check("t1_go", uart_go2, 1'b1);
    check("t1_active", active2, 1'b1);
    check("t1_grant", grant2, 1'b0);
    check("t1_udata", uart_data2, 8'h55);
    req_valid2 = 2'b00;
    @(negedge clk); #1;
    check("t1_ack_pulse", req_ack2, 2'b00);
    wait_idle2("t1");
    check("t1_active_end", active2, 1'b0);

    // Contention, no lock: strict alternation.
    do_reset();
    req_data2 = {8'hB2, 8'hA1}; req_valid2 = 2'b11;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    for (int k = 0; k < 4; k++) begin
      wait_ack2("t2_ack", ack2);
      check("t2_ack", ack2, t2_ack[k]);
      check("t2_grant", grant2, t2_gid[k]);
      if (k == 3) req_valid2 = 2'b00;
    end
    wait_idle2("t2");

    // Lock keeps requester 0 for three bytes; dropping valid releases it.
    do_reset();
    req_data2 = {8'h99, 8'h10}; req_valid2 = 2'b11; req_lock2 = 2'b01;
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    exp_q.push_back(8'h12); exp_q.push_back(8'h99);
    wait_ack2("t3_a", ack2); check("t3_ack0", ack2, 2'b01);
    req_data2[7:0] = 8'h11;
    wait_ack2("t3_b", ack2); check("t3_ack1", ack2, 2'b01);
    req_data2[7:0] = 8'h12;
    wait_ack2("t3_c", ack2); check("t3_ack2", ack2, 2'b01);
    req_valid2[0] = 1'b0;
    wait_ack2("t3_d", ack2); check("t3_ack3", ack2, 2'b10);
    check("t3_grant", grant2, 1'b1);
    req_valid2 = 2'b00; req_lock2 = 2'b00;
    wait_idle2("t3");

    // Requester data changes mid-frame do not reach the line.
    do_reset();
    req_data2[7:0] = 8'h3C; req_valid2 = 2'b01; exp_q.push_back(8'h3C);
    wait_ack2("t4", ack2); check("t4_ack", ack2, 2'b01);
    req_valid2 = 2'b00;
    repeat (12) @(negedge clk);
    #1;
    req_data2 = {8'hEE, 8'hFF};
    @(negedge clk); #1;
    check("t4_udata_mid", uart_data2, 8'h3C);
    check("t4_active_mid", active2, 1'b1);
    wait_idle2("t4");
    check("t4_udata_after", uart_data2, 8'h3C);

    // Asynchronous reset during data bits, then requester 0 served first.
    do_reset();
    req_data2[15:8] = 8'hA5; req_valid2 = 2'b10; exp_q.push_back(8'hA5);
    wait_ack2("t5", ack2); check("t5_ack", ack2, 2'b10);
    req_valid2 = 2'b00;
    check("t5_grant_pre", grant2, 1'b1);
    repeat (15) @(negedge clk);
    #1;
    check("t5_go_pre", uart_go2, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_go_rst", uart_go2, 1'b0);
    check("t5_active_rst", active2, 1'b0);
    check("t5_ack_rst", req_ack2, 2'b00);
    check("t5_grant_rst", grant2, 1'b0);
    check("t5_state_rst", state2, 2'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    req_data2 = {8'h7E, 8'h81}; req_valid2 = 2'b11;
    exp_q.push_back(8'h81); exp_q.push_back(8'h7E);
    wait_ack2("t5_a", ack2); check("t5_ack_a", ack2, 2'b01);
    req_valid2[0] = 1'b0;
    wait_ack2("t5_b", ack2); check("t5_ack_b", ack2, 2'b10);
    req_valid2 = 2'b00;
    wait_idle2("t5");

    // Round-robin wrap at 3 requesters.
    do_reset();
    req_data3 = {8'hC2, 8'hC1, 8'hC0}; req_valid3 = 3'b111;
    for (int k = 0; k < 5; k++) begin
      wait_ack3("t6", ack3);
      check("t6_ack", ack3, t6_ack[k]);
      check("t6_grant", grant3, t6_gid[k]);
      check("t6_udata", uart_data3, t6_data[k]);
      if (k == 2) req_valid3 = 3'b101;
      if (k == 4) req_valid3 = 3'b000;
    end
    wait_idle3("t6");
    check("t6_active_end", active3, 1'b0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
